// File: rtl/addc32_seq.sv
// Multi-cycle unsigned adder: DIGIT bits per clock with a registered inter-digit
// carry, behind valid/ready handshakes on both the operand and the result side.
`timescale 1ns/1ps
module addc32_seq #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x_a,
  input  logic [WIDTH-1:0] x_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] wx,
  output logic             cout
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       a_q, b_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   carry_q;
  logic                   accept;
  logic                   last_digit;
  logic [DIGIT:0]         digit_sum;
  logic [WIDTH+DIGIT-1:0] wx_cat;

  assign digit_sum  = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                    + (DIGIT+1)'(carry_q);
  // Concatenating before slicing keeps the shift legal even when DIGIT == WIDTH.
  assign wx_cat     = {digit_sum[DIGIT-1:0], wx};
  assign last_digit = (cnt_q == CNT_W'(N - 1));

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (last_digit) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wx      <= '0;
      cout    <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            carry_q <= 1'b0;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          wx      <= wx_cat[WIDTH+DIGIT-1:DIGIT];
          carry_q <= digit_sum[DIGIT];
          cnt_q   <= cnt_q + 1'b1;
          if (last_digit) cout <= digit_sum[DIGIT];
        end
        default: ;
      endcase
    end
  end

  // NOTE: the operand shift registers carry no reset; they are always loaded
  // on acceptance before any digit of them is consumed.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= x_a;
      b_q <= x_b;
    end else if (state_q == RUN) begin
      a_q <= a_q >> DIGIT;
      b_q <= b_q >> DIGIT;
    end
  end

endmodule

// File: tb/tb_addc32_seq.sv
// Directed bench for addc32_seq: latency, carry ripple, output stall, mid-run
// reset, back-to-back issue, and a short corner/random sweep.
`timescale 1ns/1ps
module tb_addc32_seq;

  localparam int WIDTH = 32;
  localparam int DIGIT = 4;
  localparam int N     = WIDTH / DIGIT;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x_a;
  logic [WIDTH-1:0] x_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] wx;
  logic             cout;

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;

  logic           prev_hold = 1'b0;
  logic [WIDTH:0] prev_res  = '0;

  always #5 clk = ~clk;

  addc32_seq #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_a       (x_a),
    .x_b       (x_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .wx        (wx),
    .cout      (cout)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Handshake invariants, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      check("mutex", 64'(in_ready & out_valid), 64'd0);
      if (prev_hold) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", 64'({cout, wx}), 64'(prev_res));
      end
      prev_hold <= out_valid & ~out_ready & ~rst;
      prev_res  <= {cout, wx};
    end
  end

  // Counts edges after the handshake edge until out_valid is seen.
  task automatic wait_out(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [WIDTH:0] exp,
                        input int stall);
    int lat;
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    x_a       = a;
    x_b       = b;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_busy"}, 64'(in_ready), 64'd0);
    wait_out(lat);
    check({tag, "_latency"}, 64'(lat), 64'(N));
    check({tag, "_sum"}, 64'({cout, wx}), 64'(exp));
    repeat (stall) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_drop_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_ready_back"}, 64'(in_ready), 64'd1);
  endtask

  logic [WIDTH-1:0] corners [5] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};

  initial begin
    int lat;
    logic [WIDTH-1:0] ra, rb;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x_a       = '0;
    x_b       = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_wx", 64'(wx), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Simple sum and full carry ripple.
    run_op("t1_5p3", 32'h5, 32'h3, 33'h0_0000_0008, 0);
    run_op("t2_ripple", 32'hFFFF_FFFF, 32'h1, 33'h1_0000_0000, 0);

    // Output stall with ignored operand pulses.
    x_a = 32'h8000_0000; x_b = 32'h8000_0000; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(lat);
    check("t3_latency", 64'(lat), 64'(N));
    check("t3_sum", 64'({cout, wx}), 64'h1_0000_0000);
    for (int i = 0; i < 5; i++) begin
      x_a = 32'h1; x_b = 32'h1; in_valid = 1'b1;
      check("t3_stall_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("t3_stall_valid", 64'(out_valid), 64'd1);
    check("t3_stall_sum", 64'({cout, wx}), 64'h1_0000_0000);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("t3_drop_valid", 64'(out_valid), 64'd0);
    check("t3_ready_back", 64'(in_ready), 64'd1);

    // Reset in the 4th RUN cycle, then redo the same operation.
    x_a = 32'h1234_5678; x_b = 32'h9ABC_DEF0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t4_in_ready", 64'(in_ready), 64'd1);
    check("t4_out_valid", 64'(out_valid), 64'd0);
    check("t4_wx", 64'(wx), 64'd0);
    check("t4_cout", 64'(cout), 64'd0);
    run_op("t4_rerun", 32'h1234_5678, 32'h9ABC_DEF0, 33'h0_ACF1_3568, 0);

    // Back-to-back with in_valid held high.
    x_a = 32'hDEAD_BEEF; x_b = 32'h2152_4111; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    x_a = 32'h7FFF_FFFF; x_b = 32'h7FFF_FFFF;
    wait_out(lat);
    check("t5a_latency", 64'(lat), 64'(N));
    check("t5a_sum", 64'({cout, wx}), 64'h1_0000_0000);
    while (in_ready !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("t5_interval", 64'(lat + 1), 64'(N + 2));
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(lat);
    check("t5b_latency", 64'(lat), 64'(N));
    check("t5b_sum", 64'({cout, wx}), 64'h0_FFFF_FFFE);
    @(posedge clk); #1;
    check("t5b_ready_back", 64'(in_ready), 64'd1);

    // Corner pairs and random pairs against a WIDTH+1-bit reference sum.
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        run_op("corner", corners[i], corners[j],
               {1'b0, corners[i]} + {1'b0, corners[j]}, j % 3);
      end
    end
    for (int k = 0; k < 150; k++) begin
      ra = $urandom;
      rb = $urandom;
      run_op("rand", ra, rb, {1'b0, ra} + {1'b0, rb}, int'($urandom_range(0, 3)));
    end

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
